// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding and default bus widths.
package apb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS-phase watchdog: counts wait cycles, flags the final allowed one.
module apb_master_wdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (count_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Combinational so the FSM leaves ACCESS on the Nth low cycle itself
   assign expired = count_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB master: local cmd/rsp handshake to an APB3 bus.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              pselx,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be at least 1");
   end

   apb_state_e        r_state;
   apb_state_e        w_next;
   logic              w_accept;
   logic              w_done;
   logic              w_tmo;
   logic              w_expired;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rsp_valid;

`ifdef APB_MASTER_TIMEOUT_EN
   logic r_rsp_err;

   apb_master_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (pclk),
      .rst     (preset),
      .clear   (r_state != ACCESS),
      .count_en((r_state == ACCESS) && !pready),
      .expired (w_expired)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_rsp_err <= 1'b0;
      end else begin
         r_rsp_err <= w_tmo;
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_expired = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_done   = 1'b0;
      w_tmo    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               w_next   = SETUP;
            end
         end
         SETUP: begin
            w_next = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else if (w_expired) begin
               w_tmo  = 1'b1;
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= w_done || w_tmo;
         if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
         end
         if (w_done && !r_pwrite) begin
            r_rdata <= prdata;
         end
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign pselx     = (r_state != IDLE);
   assign penable   = (r_state == ACCESS);
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit; used only with APB_MASTER_TIMEOUT_EN.
REQ-004 SHALL have port pclk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port preset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  local request present.
REQ-007 SHALL have port cmd_ready  output  1  request accepted this cycle when both are high.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  target address.
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data; valid with rsp_valid on reads.
REQ-013 SHALL have port rsp_err  output  1  transfer aborted by timeout; valid with rsp_valid.
REQ-014 SHALL have ports pselx, penable, pwrite (outputs, 1 bit), paddr (output, ADDR_W), pwdata (output, DATA_W), prdata (input, DATA_W), pready (input, 1), per APB.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE, combinationally from state.
REQ-017 SHALL, on cmd_valid && cmd_ready in IDLE, register cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP next cycle.
REQ-018 SHALL, in SETUP, drive pselx=1, penable=0 for exactly one cycle, then enter ACCESS.
REQ-019 SHALL, in ACCESS, drive pselx=1, penable=1, and hold paddr/pwrite/pwdata stable until pready is sampled high.
REQ-020 SHALL, on pready high in ACCESS, capture prdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged), pulse rsp_valid next cycle, and return to IDLE.
REQ-021 SHALL ignore pready outside ACCESS.
REQ-022 SHALL drive pselx=0, penable=0 in IDLE; paddr/pwdata keep last values.
REQ-023 SHALL give minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 with zero wait states; each pready-low cycle adds one.
REQ-024 SHALL allow the next command to be accepted in the same cycle rsp_valid is high (back-to-back: one IDLE cycle between transfers).
REQ-025 SHALL hold rsp_err = 0 on every response unless the timeout feature aborts the transfer.

Reset
REQ-026 SHALL, on preset high at any time, including mid-transfer, enter IDLE asynchronously and drop the in-flight transfer with no rsp_valid.
REQ-027 SHALL reset outputs to: pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready=1 after deassertion.

Configuration
REQ-028 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with pready low; on reaching TIMEOUT_CYCLES, return to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata unchanged.
REQ-029 SHALL, without APB_MASTER_TIMEOUT_EN, wait in ACCESS indefinitely, contain no counter logic, and tie rsp_err to 0.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/SETUP/ACCESS) and default ADDR_W/DATA_W constants in shared package apb_pkg.
REQ-031 SHALL implement the timeout counter as sub-module apb_master_wdog (inputs clk, rst, clear, count_en; output expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-032 SHALL cover zero-wait write: cmd addr=0x10 wdata=0xA5 accepted at N -> SETUP N+1, ACCESS N+2 with paddr=0x10 pwdata=0xA5 pwrite=1, rsp_valid at N+3, rsp_err=0.
REQ-033 SHALL cover a read with 3 wait states: pready low 3 ACCESS cycles then high with prdata=0x3C -> penable high 4 cycles, rsp_valid with rsp_rdata=0x3C at N+6.
REQ-034 SHALL cover back-to-back: cmd_valid held with two commands -> second accepted in the rsp_valid cycle of the first, exactly one IDLE cycle between pselx pulses.
REQ-035 SHALL cover reset mid-ACCESS: preset high while pready low -> pselx/penable 0 immediately, no rsp_valid, cmd_ready=1 after release.
REQ-036 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=16): pready held low -> rsp_valid with rsp_err=1 after 16 ACCESS cycles, FSM back in IDLE; without macro, no response after 100 cycles.
REQ-037 SHALL cover the stray pready: pready high in IDLE/SETUP -> no state change, no rsp_valid.
